shift_arbiter: RTL
==================

# shift_arbiter

Two-port arbiter and pipeline controller that shares the single combinational barrel shifter between the execute-stage shift path (port 0: SLL/SRL/SRA and variable forms) and the load/store byte-lane aligner (port 1). Requests arrive over valid/ready handshakes and are granted round-robin. The winning request passes through a two-stage pipeline (operand register, then result register) and returns tagged with the requester ID. Sits beside the ALU in the execute stage and owns the only instance of the shifter.

## Interface
- DATA_WIDTH, 32, operand/result width; shift amount is always B[4:0].
- clk  in  1  clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- req0_valid / req1_valid  in  1  request present on port 0 / 1.
- req0_ready / req1_ready  out  1  port accepted this cycle when valid&ready.
- req0_A / req1_A  in  DATA_WIDTH  value to shift.
- req0_B / req1_B  in  DATA_WIDTH  shift amount; only bits [4:0] used.
- req0_op / req1_op  in  2  00 SLL, 10 SRL, 11 SRA, 01 reserved.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer accepts result.
- resp_data  out  DATA_WIDTH  shift result.
- resp_id  out  1  requester of resp_data (0 or 1).

## Operation
- Arbitration: only one port sees ready=1 in a cycle. If one port is valid, it is granted. If both are valid, the port other than last_grant is granted. last_grant updates only on an accepted handshake. After reset, last_grant=1, so port 0 wins the first tie.
- Stage S1 holds {A, B[4:0], op, id, s1_valid}. Stage S2 holds {result, id, s2_valid}.
- s2_adv = !s2_valid | resp_ready.
- s1_adv = !s1_valid | s2_adv.
- reqN_ready = grantN & s1_adv.
- On s2_adv, S2 loads the shifter output computed from S1 and s2_valid<=s1_valid. On s1_adv, S1 loads the granted request and s1_valid<=handshake.
- Shift semantics: SLL = A<<sh. SRL = logical A>>sh. SRA = arithmetic A>>>sh with sign fill. sh=B[4:0], so B=32 shifts by 0. op 01 yields result 0 and still completes as a normal transaction.
- A request is accepted only on valid&ready. reqN_valid may drop without a handshake; no commitment is made until acceptance.
- resp_data and resp_id stay stable while resp_valid & !resp_ready.

## Timing
- Reset (async assert, sync deassert): s1_valid=0, s2_valid=0, resp_valid=0, resp_data=0, resp_id=0, last_grant=1. req0_ready and req1_ready are low unless the corresponding valid is high after reset.
- Latency: request accepted at edge N gives resp_valid=1 after edge N+1. This is 2 cycles with no stall.
- Throughput: 1 result/cycle with resp_ready held high.
- Full pipeline (both stages valid, resp_ready=0): both req readys are 0. When resp_ready rises, the same cycle drains S2, advances S1 and accepts a new request.
- A combinational path exists from resp_ready to reqN_ready. Consumers must not derive resp_ready from reqN_ready.
- Reset asserted mid-transaction discards both stages immediately, with no partial response.

## Structure
- The shared package holds DATA_WIDTH, the op encodings (SHIFT_SLL=2'b00, SHIFT_SRL=2'b10, SHIFT_SRA=2'b11) and the port-ID constants.
- Sub-module: the existing combinational `shifter` is instantiated once between S1 and S2. Its ports are A, B, Shiftop and Result. No shift logic is duplicated in this block.
- Arbiter logic (grant plus last_grant flop) stays inline; it is under 20 lines.

## Test plan
- Single request: port 0, A=0x0000_00F0, B=4, op=00. Expect resp_valid 2 cycles later with resp_data=0x0000_0F00 and resp_id=0.
- Arithmetic/logical split: port 1, A=0x8000_0000, B=31. With op=11, expect 0xFFFF_FFFF, id=1. With op=10, expect 0x0000_0001. With B=32 and op=10, expect 0x8000_0000.
- Tie and fairness: both ports valid every cycle for 6 cycles, resp_ready=1. Grants alternate 0,1,0,1,0,1 and the resp_id sequence matches, with one result per cycle.
- Backpressure: stream 3 port-0 requests with resp_ready=0. The first two are accepted, then req0_ready=0. resp_data is held stable. Raising resp_ready delivers results in order with no loss or duplication.
- Reserved op: op=01, A=0xDEAD_BEEF, B=3. Expect resp_data=0, resp_id as sent, and a normal handshake.
- Reset mid-flight: drop resetn with both stages valid. resp_valid goes to 0 immediately. After release, the next tie is granted to port 0.

Source files
------------

// File: rtl/shift_arbiter_pkg.sv
// Shared constants for the shift arbiter: datapath width, shift op encodings
// and requester IDs.
package shift_arbiter_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int SHAMT_W    = 5;

  localparam logic [1:0] SHIFT_SLL = 2'b00;
  localparam logic [1:0] SHIFT_SRL = 2'b10;
  localparam logic [1:0] SHIFT_SRA = 2'b11;

  localparam logic PORT0_ID = 1'b0;
  localparam logic PORT1_ID = 1'b1;
endpackage

// File: rtl/shift_arbiter_shifter.sv
// Combinational barrel shifter shared by the execute shift path and the
// load/store lane aligner. The reserved op encoding produces zero.
module shifter
  import shift_arbiter_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [SHAMT_W-1:0]    B,
  input  logic [1:0]            Shiftop,
  output logic [DATA_WIDTH-1:0] Result
);
  always_comb begin
    Result = '0;
    case (Shiftop)
      SHIFT_SLL: Result = A << B;
      SHIFT_SRL: Result = A >> B;
      SHIFT_SRA: Result = $signed(A) >>> B;
      default:   Result = '0;
    endcase
  end
endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter in front of the single shifter, with an operand stage
// (S1) and a result stage (S2) returning results tagged by requester ID.
module shift_arbiter
  import shift_arbiter_pkg::*;
(
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [DATA_WIDTH-1:0] req0_A,
  input  logic [DATA_WIDTH-1:0] req0_B,
  input  logic [1:0]            req0_op,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [DATA_WIDTH-1:0] req1_A,
  input  logic [DATA_WIDTH-1:0] req1_B,
  input  logic [1:0]            req1_op,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  resp_id
);
  // Handshake: a transfer happens on a cycle where valid & ready are both high
  // at the rising edge; valid may drop before that, and the response holds
  // data and id steady while resp_valid & !resp_ready.
  logic                  last_grant_q;
  logic                  grant0, grant1, hs, hs_id;
  logic                  s1_adv, s2_adv;
  logic                  s1_valid_q, s1_id_q;
  logic [DATA_WIDTH-1:0] s1_a_q;
  logic [SHAMT_W-1:0]    s1_sh_q;
  logic [1:0]            s1_op_q;
  logic                  s2_valid_q, s2_id_q;
  logic [DATA_WIDTH-1:0] s2_data_q;
  logic [DATA_WIDTH-1:0] shift_res;
  logic                  unused_b_hi;

  assign unused_b_hi = ^{req0_B[DATA_WIDTH-1:SHAMT_W], req1_B[DATA_WIDTH-1:SHAMT_W]};

  assign s2_adv = !s2_valid_q || resp_ready;
  assign s1_adv = !s1_valid_q || s2_adv;

  // On a tie the port that did not win the last accepted handshake goes next.
  assign grant0 = req0_valid && (!req1_valid || (last_grant_q == PORT1_ID));
  assign grant1 = req1_valid && !grant0;

  assign req0_ready = grant0 && s1_adv;
  assign req1_ready = grant1 && s1_adv;
  assign hs         = (req0_valid && req0_ready) || (req1_valid && req1_ready);
  assign hs_id      = grant1 ? PORT1_ID : PORT0_ID;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_grant_q <= PORT1_ID;
    end else if (hs) begin
      last_grant_q <= hs_id;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1_valid_q <= 1'b0;
      s1_id_q    <= PORT0_ID;
      s1_a_q     <= '0;
      s1_sh_q    <= '0;
      s1_op_q    <= SHIFT_SLL;
    end else if (s1_adv) begin
      s1_valid_q <= hs;
      if (hs) begin
        s1_id_q <= hs_id;
        s1_a_q  <= grant1 ? req1_A : req0_A;
        s1_sh_q <= grant1 ? req1_B[SHAMT_W-1:0] : req0_B[SHAMT_W-1:0];
        s1_op_q <= grant1 ? req1_op : req0_op;
      end
    end
  end

  shifter u_shifter (
    .A       (s1_a_q),
    .B       (s1_sh_q),
    .Shiftop (s1_op_q),
    .Result  (shift_res)
  );

  // Result payload only changes when a real operand moves in, keeping the
  // output quiet across bubbles.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s2_valid_q <= 1'b0;
      s2_id_q    <= PORT0_ID;
      s2_data_q  <= '0;
    end else if (s2_adv) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_id_q   <= s1_id_q;
        s2_data_q <= shift_res;
      end
    end
  end

  assign resp_valid = s2_valid_q;
  assign resp_data  = s2_data_q;
  assign resp_id    = s2_id_q;
endmodule
